// File: rtl/gcm_ghash_engine.sv
// Digit-serial GHASH and tag engine for AES-GCM: absorbs AAD/CT blocks, appends the length block, emits a truncated tag and compare.
// Vectors are stored with GCM bit 0 (first byte MSB) at index 127, so hex literals read in GCM order.
module gcm_ghash_engine #(
    parameter int unsigned DIGIT_W   = 8,
    parameter int unsigned TAG_BYTES = 16,
    parameter int unsigned LEN_W     = 36
) (
    input  logic         iClk,
    input  logic         iRstn,
    input  logic         iStart,
    input  logic [127:0] iHashKey,
    input  logic [127:0] iEkY0,
    input  logic [127:0] iData,
    input  logic         iData_valid,
    input  logic         iData_type,
    input  logic [4:0]   iData_bytes,
    output logic         oReady,
    input  logic         iFinish,
    input  logic [127:0] iTag,
    output logic [127:0] oTag,
    output logic         oTag_valid,
    output logic         oAuthentic,
    output logic         oError
);
    localparam int unsigned N     = 128 / DIGIT_W;
    localparam int unsigned CNT_W = 8;
    localparam logic [127:0] R_POLY = {8'he1, 120'h0};

    // Keep bytes 0..n-1 (byte 0 is the most significant byte of the vector).
    function automatic logic [127:0] byte_mask(input logic [4:0] n);
        logic [127:0] m;
        m = '0;
        for (int k = 0; k < 16; k++) begin
            if (5'(k) < n) m[127-8*k -: 8] = 8'hff;
        end
        return m;
    endfunction

    localparam logic [127:0] TAG_MASK = byte_mask(5'(TAG_BYTES));

    // One digit of the shift-and-add GF(2^128) multiply, X consumed MSB first.
    function automatic logic [255:0] gf_step(input logic [127:0] z_in, input logic [127:0] v_in,
                                             input logic [DIGIT_W-1:0] d);
        logic [127:0] z;
        logic [127:0] v;
        z = z_in;
        v = v_in;
        for (int i = DIGIT_W - 1; i >= 0; i--) begin
            if (d[i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ R_POLY) : (v >> 1);
        end
        return {z, v};
    endfunction

    typedef enum logic [2:0] {IDLE, ACCEPT, MULT, LENMUL, TAG} state_t;
    state_t state_q, state_d;

    logic [127:0]     acc_q, acc_d, h_q, h_d, eky0_q, eky0_d, x_q, x_d, z_q, z_d, v_q, v_d;
    logic [127:0]     itag_q, itag_d, tag_q, tag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] aad_cnt_q, aad_cnt_d, ct_cnt_q, ct_cnt_d;
    logic             aad_part_q, aad_part_d, ct_part_q, ct_part_d;
    logic             err_q, err_d, ready_q, ready_d, tag_valid_q, tag_valid_d, auth_q, auth_d;

    logic [4:0]       n_bytes;
    logic [127:0]     masked, len_blk, tag_full, step_z, step_v;
    logic [LEN_W:0]   sum;
    logic             ovf, blk_err, last;

    always_comb begin
        n_bytes  = (iData_bytes == 5'd0 || iData_bytes > 5'd16) ? 5'd16 : iData_bytes;
        masked   = iData & byte_mask(n_bytes);
        sum      = {1'b0, (iData_type ? ct_cnt_q : aad_cnt_q)} + (LEN_W+1)'(n_bytes);
        ovf      = sum[LEN_W];
        blk_err  = (~iData_type & (ct_cnt_q != '0)) | (iData_type ? ct_part_q : aad_part_q) | ovf;
        len_blk  = {64'({aad_cnt_q, 3'b000}), 64'({ct_cnt_q, 3'b000})};
        {step_z, step_v} = gf_step(z_q, v_q, x_q[127 -: DIGIT_W]);
        last     = (cnt_q == CNT_W'(N - 1));
        tag_full = step_z ^ eky0_q;
    end

    // State register
    always_ff @(posedge iClk) begin
        if (!iRstn) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; iStart overrides every state
    always_comb begin
        state_d = state_q;
        if (iStart) begin
            state_d = ACCEPT;
        end else begin
            case (state_q)
                ACCEPT: begin
                    if (iData_valid)  state_d = blk_err ? ACCEPT : MULT;
                    else if (iFinish) state_d = LENMUL;
                end
                MULT:    if (last) state_d = ACCEPT;
                LENMUL:  if (last) state_d = TAG;
                TAG:     state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        acc_d       = acc_q;
        h_d         = h_q;
        eky0_d      = eky0_q;
        x_d         = x_q;
        z_d         = z_q;
        v_d         = v_q;
        cnt_d       = cnt_q;
        aad_cnt_d   = aad_cnt_q;
        ct_cnt_d    = ct_cnt_q;
        aad_part_d  = aad_part_q;
        ct_part_d   = ct_part_q;
        err_d       = err_q;
        itag_d      = itag_q;
        tag_d       = tag_q;
        tag_valid_d = 1'b0;
        auth_d      = 1'b0;
        ready_d     = (state_d == ACCEPT);
        if (iStart) begin
            acc_d      = '0;
            h_d        = iHashKey;
            eky0_d     = iEkY0;
            cnt_d      = '0;
            aad_cnt_d  = '0;
            ct_cnt_d   = '0;
            aad_part_d = 1'b0;
            ct_part_d  = 1'b0;
            err_d      = 1'b0;
            tag_d      = '0;
        end else begin
            case (state_q)
                ACCEPT: begin
                    if (iData_valid) begin
                        if (blk_err) begin
                            err_d = 1'b1;
                            if (ovf) begin
                                if (iData_type) ct_cnt_d  = '1;
                                else            aad_cnt_d = '1;
                            end
                        end else begin
                            x_d   = acc_q ^ masked;
                            z_d   = '0;
                            v_d   = h_q;
                            cnt_d = '0;
                            if (iData_type) begin
                                ct_cnt_d  = sum[LEN_W-1:0];
                                ct_part_d = (n_bytes != 5'd16);
                            end else begin
                                aad_cnt_d  = sum[LEN_W-1:0];
                                aad_part_d = (n_bytes != 5'd16);
                            end
                        end
                    end else if (iFinish) begin
                        x_d    = acc_q ^ len_blk;
                        z_d    = '0;
                        v_d    = h_q;
                        cnt_d  = '0;
                        itag_d = iTag;
                    end
                end
                MULT, LENMUL: begin
                    z_d   = step_z;
                    v_d   = step_v;
                    x_d   = x_q << DIGIT_W;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last) begin
                        acc_d = step_z;
                        if (state_q == LENMUL) begin
                            tag_d       = tag_full & TAG_MASK;
                            tag_valid_d = 1'b1;
                            auth_d      = (((tag_full ^ itag_q) & TAG_MASK) == '0) & ~err_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRstn) begin
            acc_q <= '0; h_q <= '0; eky0_q <= '0; x_q <= '0; z_q <= '0; v_q <= '0;
            itag_q <= '0; tag_q <= '0; cnt_q <= '0; aad_cnt_q <= '0; ct_cnt_q <= '0;
            aad_part_q <= 1'b0; ct_part_q <= 1'b0; err_q <= 1'b0;
            ready_q <= 1'b0; tag_valid_q <= 1'b0; auth_q <= 1'b0;
        end else begin
            acc_q <= acc_d; h_q <= h_d; eky0_q <= eky0_d; x_q <= x_d; z_q <= z_d; v_q <= v_d;
            itag_q <= itag_d; tag_q <= tag_d; cnt_q <= cnt_d; aad_cnt_q <= aad_cnt_d; ct_cnt_q <= ct_cnt_d;
            aad_part_q <= aad_part_d; ct_part_q <= ct_part_d; err_q <= err_d;
            ready_q <= ready_d; tag_valid_q <= tag_valid_d; auth_q <= auth_d;
        end
    end

    assign oReady     = ready_q;
    assign oTag       = tag_q;
    assign oTag_valid = tag_valid_q;
    assign oAuthentic = auth_q;
    assign oError     = err_q;
endmodule

// File: tb/tb_gcm_ghash_engine.sv
// Scoreboarded bench for gcm_ghash_engine: three instances (DIGIT_W 8/1/128, TAG_BYTES 16/16/12) share one stimulus stream.
module tb_gcm_ghash_engine;
    localparam logic [127:0] H_K   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] EK_K  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [127:0] C_K   = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] TAG_K = 128'hab6e47d42cec13bdf53a67b21257bddf;
    localparam logic [127:0] R_POLY = {8'he1, 120'h0};

    typedef struct packed {
        logic [127:0] tag;
        logic         auth;
    } sb_t;

    logic         iClk, iRstn, iStart, iData_valid, iData_type, iFinish;
    logic [127:0] iHashKey, iEkY0, iData, iTag;
    logic [4:0]   iData_bytes;
    logic         rdy [3];
    logic         tv  [3];
    logic         auth[3];
    logic         err [3];
    logic [127:0] otag[3];

    int  n_checks = 0;
    int  n_errors = 0;
    sb_t q0[$], q1[$], q2[$];

    logic [127:0] m_acc, m_h, m_ek;
    longint       m_aad, m_ct;
    bit           m_ap, m_cp, m_err;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned GDW = (g == 0) ? 8 : ((g == 1) ? 1 : 128);
        localparam int unsigned GTB = (g == 2) ? 12 : 16;
        gcm_ghash_engine #(.DIGIT_W(GDW), .TAG_BYTES(GTB), .LEN_W(36)) u_dut (
            .iClk(iClk), .iRstn(iRstn), .iStart(iStart), .iHashKey(iHashKey), .iEkY0(iEkY0),
            .iData(iData), .iData_valid(iData_valid), .iData_type(iData_type), .iData_bytes(iData_bytes),
            .oReady(rdy[g]), .iFinish(iFinish), .iTag(iTag), .oTag(otag[g]),
            .oTag_valid(tv[g]), .oAuthentic(auth[g]), .oError(err[g])
        );
    end

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    function automatic int n_of(input int g);
        return (g == 0) ? 16 : ((g == 1) ? 128 : 1);
    endfunction

    function automatic int tb_of(input int g);
        return (g == 2) ? 12 : 16;
    endfunction

    function automatic logic [127:0] bmask(input int n);
        logic [127:0] m;
        m = '0;
        for (int k = 0; k < 16; k++) if (k < n) m[127-8*k -: 8] = 8'hff;
        return m;
    endfunction

    // Reference GF(2^128) multiply in GCM bit order (bit i of X is vector index 127-i).
    function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z, v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            if (v[0]) v = (v >> 1) ^ R_POLY;
            else      v = v >> 1;
        end
        return z;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit model_absorb(input logic [127:0] d, input logic typ, input int nb);
        int n;
        n = (nb == 0 || nb > 16) ? 16 : nb;
        if ((!typ && m_ct != 0) || (typ ? m_cp : m_ap)) begin
            m_err = 1'b1;
            return 1'b0;
        end
        m_acc = gf_mul(m_acc ^ (d & bmask(n)), m_h);
        if (typ) begin m_ct += longint'(n); m_cp = (n != 16); end
        else     begin m_aad += longint'(n); m_ap = (n != 16); end
        return 1'b1;
    endfunction

    function automatic logic [127:0] model_tag();
        return gf_mul(m_acc ^ {64'(m_aad * 8), 64'(m_ct * 8)}, m_h) ^ m_ek;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge iClk);
            ok = rdy[0] & rdy[1] & rdy[2];
        end
        if (!ok) check("ready_timeout", 128'(0), 128'(1));
    endtask

    task automatic do_start(input logic [127:0] h, input logic [127:0] ek);
        @(negedge iClk);
        iStart = 1'b1; iHashKey = h; iEkY0 = ek;
        @(negedge iClk);
        iStart = 1'b0;
        m_acc = '0; m_h = h; m_ek = ek; m_aad = 0; m_ct = 0; m_ap = 0; m_cp = 0; m_err = 0;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("start_ready%0d", g), 128'(rdy[g]), 128'(1));
            check($sformatf("start_err%0d", g), 128'(err[g]), 128'(0));
        end
    endtask

    // Count busy (oReady low) cycles after a handshake for every instance.
    task automatic measure_ready(input bit mult);
        bit done[3];
        int cyc;
        done = '{1'b0, 1'b0, 1'b0};
        for (int g = 0; g < 3; g++) check($sformatf("err%0d", g), 128'(err[g]), 128'(m_err));
        cyc = 1;
        while (cyc <= 300 && !(done[0] && done[1] && done[2])) begin
            for (int g = 0; g < 3; g++) begin
                if (!done[g] && rdy[g]) begin
                    check($sformatf("busy_cycles%0d", g), 128'(cyc - 1), 128'(mult ? n_of(g) : 0));
                    done[g] = 1'b1;
                end
            end
            if (!(done[0] && done[1] && done[2])) begin
                @(negedge iClk);
                cyc++;
            end
        end
        for (int g = 0; g < 3; g++) if (!done[g]) check($sformatf("busy_timeout%0d", g), 128'(0), 128'(1));
    endtask

    task automatic send(input logic [127:0] d, input logic typ, input int nb, input bit measure);
        bit mult;
        wait_ready();
        iData = d; iData_type = typ; iData_bytes = 5'(nb); iData_valid = 1'b1;
        mult = model_absorb(d, typ, nb);
        @(negedge iClk);
        iData_valid = 1'b0;
        if (measure) measure_ready(mult);
    endtask

    task automatic do_finish(input logic [127:0] itag, input logic [127:0] full);
        bit done[3];
        int cyc;
        sb_t e;
        wait_ready();
        for (int g = 0; g < 3; g++) begin
            e.tag  = full & bmask(tb_of(g));
            e.auth = (((full ^ itag) & bmask(tb_of(g))) == '0) && !m_err;
            case (g)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        iFinish = 1'b1; iTag = itag;
        @(negedge iClk);
        iFinish = 1'b0;
        done = '{1'b0, 1'b0, 1'b0};
        cyc = 1;
        while (cyc <= 300 && !(done[0] && done[1] && done[2])) begin
            for (int g = 0; g < 3; g++) begin
                if (!done[g] && tv[g]) begin
                    check($sformatf("tag_latency%0d", g), 128'(cyc), 128'(n_of(g) + 1));
                    done[g] = 1'b1;
                end
            end
            if (!(done[0] && done[1] && done[2])) begin
                @(negedge iClk);
                cyc++;
            end
        end
        for (int g = 0; g < 3; g++) if (!done[g]) check($sformatf("tag_timeout%0d", g), 128'(0), 128'(1));
        @(negedge iClk);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("tv_pulse%0d", g), 128'(tv[g]), 128'(0));
            check($sformatf("auth_idle%0d", g), 128'(auth[g]), 128'(0));
            check($sformatf("tag_hold%0d", g), otag[g], full & bmask(tb_of(g)));
        end
    endtask

    // Scoreboard: pop the expected tag when an instance reports one.
    always @(negedge iClk) begin
        for (int g = 0; g < 3; g++) begin
            if (tv[g] === 1'b1) begin
                sb_t e;
                bit  got;
                got = 1'b0;
                e   = '0;
                case (g)
                    0:       if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                    1:       if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                    default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
                endcase
                if (!got) check($sformatf("unexpected_tag%0d", g), 128'(1), 128'(0));
                else begin
                    check($sformatf("tag%0d", g), otag[g], e.tag);
                    check($sformatf("authentic%0d", g), 128'(auth[g]), 128'(e.auth));
                end
            end
        end
    end

    task automatic check_zero_outputs(input string ctx);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s_ready%0d", ctx, g), 128'(rdy[g]), 128'(0));
            check($sformatf("%s_tv%0d", ctx, g), 128'(tv[g]), 128'(0));
            check($sformatf("%s_auth%0d", ctx, g), 128'(auth[g]), 128'(0));
            check($sformatf("%s_err%0d", ctx, g), 128'(err[g]), 128'(0));
            check($sformatf("%s_tag%0d", ctx, g), otag[g], 128'(0));
        end
    endtask

    initial begin
        logic [127:0] r1, r2, r3;
        iRstn = 1'b0; iStart = 1'b0; iData_valid = 1'b0; iData_type = 1'b0; iFinish = 1'b0;
        iHashKey = '0; iEkY0 = '0; iData = '0; iTag = '0; iData_bytes = '0;
        m_acc = '0; m_h = '0; m_ek = '0; m_aad = 0; m_ct = 0; m_ap = 0; m_cp = 0; m_err = 0;
        repeat (3) @(negedge iClk);
        check_zero_outputs("reset");
        iRstn = 1'b1;

        // Empty message: tag equals E_K(Y0)
        do_start(H_K, EK_K);
        do_finish(EK_K, EK_K);

        // One full CT block, known answer; then MSB of iTag flipped
        do_start(H_K, EK_K);
        send(C_K, 1'b1, 16, 1'b1);
        do_finish(TAG_K, TAG_K);
        do_start(H_K, EK_K);
        send(C_K, 1'b1, 16, 1'b1);
        do_finish(TAG_K ^ {1'b1, 127'h0}, TAG_K);

        // Last tag byte corrupted: only the 12-byte instance still authenticates
        do_start(H_K, EK_K);
        send(C_K, 1'b1, 16, 1'b1);
        do_finish(TAG_K ^ 128'hff, TAG_K);

        // AAD 16+4, CT 7 with garbage beyond the valid bytes
        r1 = rnd128(); r2 = rnd128(); r3 = rnd128();
        do_start(rnd128(), rnd128());
        send(r1, 1'b0, 16, 1'b1);
        send(r2, 1'b0, 4, 1'b1);
        send(r3, 1'b1, 7, 1'b1);
        do_finish(model_tag(), model_tag());

        // Byte count 0 means a full block; CT 16 + 5
        do_start(rnd128(), rnd128());
        send(rnd128(), 1'b0, 0, 1'b1);
        send(rnd128(), 1'b1, 16, 1'b1);
        send(rnd128(), 1'b1, 5, 1'b1);
        do_finish(model_tag(), model_tag());

        // AAD after CT: error, block not absorbed, tag not authentic
        do_start(H_K, EK_K);
        send(C_K, 1'b1, 16, 1'b1);
        send(rnd128(), 1'b0, 16, 1'b1);
        do_finish(model_tag(), model_tag());
        do_start(H_K, EK_K);

        // Block after a partial block of the same type
        send(rnd128(), 1'b0, 3, 1'b1);
        send(rnd128(), 1'b0, 16, 1'b1);
        do_finish(model_tag(), model_tag());

        // iStart during MULT aborts, then a fresh message
        do_start(H_K, EK_K);
        send(rnd128(), 1'b1, 16, 1'b0);
        repeat (2) @(negedge iClk);
        do_start(H_K, EK_K);
        send(C_K, 1'b1, 16, 1'b1);
        do_finish(TAG_K, TAG_K);

        // Reset during MULT, then a fresh message
        do_start(H_K, EK_K);
        send(rnd128(), 1'b0, 16, 1'b0);
        repeat (2) @(negedge iClk);
        iRstn = 1'b0;
        @(negedge iClk);
        check_zero_outputs("midreset");
        iRstn = 1'b1;
        do_start(H_K, EK_K);
        send(C_K, 1'b1, 16, 1'b1);
        do_finish(TAG_K, TAG_K);

        repeat (4) @(negedge iClk);
        check("sb_left0", 128'(q0.size()), 128'(0));
        check("sb_left1", 128'(q1.size()), 128'(0));
        check("sb_left2", 128'(q2.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/gcm_ghash_engine.md
Name: gcm_ghash_engine

Overview:
- Parametrised GHASH/tag engine for the AES-GCM datapath, replacing the single-cycle GHASH plus fixed-block control.
- Absorbs AAD and cipher-text blocks, including byte-granular partial last blocks.
- Tracks lengths and generates the len(A)||len(C) block itself; produces a truncatable tag and its authentication compare.
- Sits between the GCTR block (supplies H, E_K(Y0) and cipher text) and the top-level AES-GCM controller.

Parameters:
- DIGIT_W, 8, bits of the multiplier operand processed per cycle; legal values 1,2,4,8,16,32,64,128; N = 128/DIGIT_W multiply cycles.
- TAG_BYTES, 16, tag length in bytes, 4..16.
- LEN_W, 36, width of each internal byte counter (AAD, CT).

Ports:
- iClk  in  1  clock
- iRstn  in  1  reset
- iStart  in  1  pulse; aborts any operation, clears accumulator/counters/error, samples iHashKey and iEkY0
- iHashKey  in  128  H, bit 0 = MSB
- iEkY0  in  128  E_K(Y0)
- iData  in  128  block; byte k = iData[8k:8k+7]
- iData_valid  in  1  block offered
- iData_type  in  1  0 = AAD, 1 = cipher text
- iData_bytes  in  5  valid bytes from byte 0; 1..16, and 0 or >16 treated as 16
- oReady  out  1  block/finish can be accepted
- iFinish  in  1  pulse; close message and compute tag
- iTag  in  128  expected tag, sampled with iFinish
- oTag  out  128  tag; bytes >= TAG_BYTES forced 0
- oTag_valid  out  1  one-cycle pulse
- oAuthentic  out  1  valid with oTag_valid
- oError  out  1  sticky protocol error

Behaviour:
- Reset is synchronous, active-low: iRstn, clock iClk. Reset values: all outputs 0, state IDLE, acc/H/EkY0/counters 0.
- States: IDLE, ACCEPT, MULT, LENMUL, TAG.
- iStart has priority over everything except reset, in any state: the next state is ACCEPT with oReady = 1 the following cycle.
- IDLE: oReady = 0. Data and finish are ignored.
- ACCEPT: oReady = 1. Handshake is iData_valid & oReady on the same cycle T.
  - Masked block: bytes >= count are zeroed. X = acc ^ masked.
  - The counter for iData_type is incremented by the byte count.
  - MULT runs cycles T+1..T+N; oReady = 0 throughout. ACCEPT resumes at T+N+1 with acc = X*H in GF(2^128), polynomial x^128+x^7+x^2+x+1, GCM bit order. The multiply consumes DIGIT_W bits of X per cycle, MSB first.
- iFinish in ACCEPT:
  - If iData_valid is also high, the data is accepted and iFinish is ignored.
  - Otherwise X = acc ^ {aad_bytes*8 as 64 bits, ct_bytes*8 as 64 bits}. LENMUL runs cycles T+1..T+N.
  - TAG at T+N+1: oTag = (acc ^ EkY0) truncated; oTag_valid = 1; oAuthentic = (top TAG_BYTES of iTag == top TAG_BYTES of tag) & ~oError. IDLE follows at T+N+2.
- oTag holds its value until the next iStart/reset. oAuthentic is 0 outside the TAG cycle.
- Protocol errors: oError is set and the block is consumed but not absorbed (acc and counters unchanged). The cases are:
  - AAD accepted after any cipher text.
  - A block accepted after a partial (<16) block of the same type.
  - A byte counter would exceed 2^LEN_W - 1; that counter saturates.
- oError is cleared only by iStart or reset. A tag is still produced with oAuthentic = 0.
- An empty message (finish immediately) is legal: the length block is 0 and the tag is EkY0.

Test Plan:
- H = 66e94bd4ef8a2c3b884cfa59ca342b2e, EkY0 = 58e2fccefa7e3061367f1d57a4e7455a, iStart then iFinish -> oTag = 58e2fccefa7e3061367f1d57a4e7455a, oTag_valid 1 cycle, exactly N+1 cycles after finish.
- Same H/EkY0, one CT block 0388dace60b6a392f328c2b971b2fe78 (16 bytes), finish with iTag = ab6e47d42cec13bdf53a67b21257bddf -> oTag equal, oAuthentic = 1. Flip iTag bit 0 -> oAuthentic = 0.
- Sweep DIGIT_W in {1, 8, 128} on the previous case -> identical tag. oReady low for exactly 128, 16 and 1 cycles after each handshake.
- AAD 20 bytes (16 + 4 partial) then CT 7 bytes, with random data -> tag matches the software GCM model. Length block = 00..a0 || 00..38.
- CT block then AAD block -> oError = 1, AAD not absorbed, oAuthentic = 0 even with a model-correct iTag. iStart clears oError.
- TAG_BYTES = 12 -> oTag bytes 12..15 = 0. Corrupt iTag byte 15 -> oAuthentic still 1. Reset or iStart during MULT -> outputs 0 / ACCEPT next cycle, then a fresh message gives the correct tag.
